simd_avg_pipe: RTL and testbench

- Pipelined, parametrised successor to the SPU combinational byte-average unit.
- Performs per-element unsigned SIMD ops on two REG_W-bit register operands: rounded average, floor average and absolute difference.
- Sits in the SPU even (fixed-point) pipe, between operand fetch and writeback.
- Uses a valid/ready handshake and carries a destination-register tag.

---
 rtl/simd_avg_pkg.sv | 28 ++
 rtl/simd_avg_pipe_if.sv | 32 +++
 rtl/simd_avg_lane.sv | 44 ++++
 rtl/simd_avg_pipe.sv | 156 +++++++++++++++
 tb/tb_simd_avg_pipe.sv | 550 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/simd_avg_pkg.sv
// Shared types and helpers for the SIMD average/abs-diff pipe.
// Op encoding, legal element widths and lane-count helper.
package simd_avg_pkg;

  typedef enum logic [1:0] {
    AVGR = 2'b00,
    AVGF = 2'b01,
    ABSD = 2'b10,
    RSVD = 2'b11
  } simd_avg_op_e;

  localparam int ELEM_W_8  = 8;
  localparam int ELEM_W_16 = 16;
  localparam int ELEM_W_32 = 32;

  function automatic bit elem_w_ok(input int ew);
    return (ew == ELEM_W_8) || (ew == ELEM_W_16) ||
           (ew == ELEM_W_32);
  endfunction

  function automatic int lane_count(
    input int reg_w,
    input int elem_w
  );
    return reg_w / elem_w;
  endfunction

endpackage

// File: rtl/simd_avg_pipe_if.sv
// Operand/result valid-ready bundle for simd_avg_pipe.
// master drives beats and out_ready; slave is the pipe.
interface simd_avg_pipe_if #(
  parameter int REG_W = 128,
  parameter int TAG_W = 7
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [REG_W-1:0] register_RA;
  logic [REG_W-1:0] register_RB;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [REG_W-1:0] register_RT;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport master (
    output in_valid, in_op, register_RA,
    output register_RB, in_tag, out_ready,
    input  in_ready, out_valid, register_RT,
    input  out_tag, out_err
  );

  modport slave (
    input  in_valid, in_op, register_RA,
    input  register_RB, in_tag, out_ready,
    output in_ready, out_valid, register_RT,
    output out_tag, out_err
  );
endinterface

// File: rtl/simd_avg_lane.sv
// One element of the SIMD unit: a/b/op -> ELEM_W+1 partial,
// then partial/op -> final ELEM_W result (shift or pass).
module simd_avg_lane
  import simd_avg_pkg::*;
#(
  parameter int ELEM_W = 8
) (
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  input  simd_avg_op_e      op,
  output logic [ELEM_W:0]   pre,
  input  logic [ELEM_W:0]   fin_pre,
  input  simd_avg_op_e      fin_op,
  output logic [ELEM_W-1:0] res
);
  logic [ELEM_W:0]   sum;
  logic [ELEM_W-1:0] dif;

  // Rounding bit folded into the sum so the
  // final stage only has to drop the LSB.
  always_comb begin
    sum = {1'b0, a} + {1'b0, b} +
          {{ELEM_W{1'b0}}, op == AVGR};
    dif = (a >= b) ? a - b : b - a;
    pre = '0;
    unique case (1'b1)
      (op == AVGR),
      (op == AVGF): pre = sum;
      (op == ABSD): pre = {1'b0, dif};
      default:      pre = '0;
    endcase
  end

  always_comb begin
    res = '0;
    unique case (1'b1)
      (fin_op == AVGR),
      (fin_op == AVGF): res = fin_pre[ELEM_W:1];
      (fin_op == ABSD): res = fin_pre[ELEM_W-1:0];
      default:          res = '0;
    endcase
  end

endmodule

// File: rtl/simd_avg_pipe.sv
// Elastic STAGES-deep pipe: per-element AVGR/AVGF/ABSD, tag, err.
// Ports: clk, rst_n, io (slave); SIMD_AVG_PERF_CNT_EN adds perf_*.
module simd_avg_pipe
  import simd_avg_pkg::*;
#(
  parameter int REG_W  = 128,
  parameter int ELEM_W = 8,
  parameter int STAGES = 2,
  parameter int TAG_W  = 7
) (
  input logic            clk,
  input logic            rst_n,
  simd_avg_pipe_if.slave io
`ifdef SIMD_AVG_PERF_CNT_EN
  ,
  output logic [31:0]    perf_ops,
  output logic [31:0]    perf_stall
`endif
);
  localparam int LANES = lane_count(REG_W, ELEM_W);
  localparam int PW    = ELEM_W + 1;
  localparam int PRE_W = LANES * PW;

  simd_avg_op_e     in_op;
  simd_avg_op_e     fin_op;
  logic [PRE_W-1:0] pre_c;
  logic [PRE_W-1:0] fin_pre;
  logic [REG_W-1:0] fin_res;
  logic [TAG_W-1:0] fin_tag;
  logic             fin_v;

  logic             v_last;
  logic             ld_last;
  logic [REG_W-1:0] rt_q;
  logic [TAG_W-1:0] tag_q;
  logic             err_q;

  assign in_op   = simd_avg_op_e'(io.in_op);
  assign ld_last = !v_last || io.out_ready;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    simd_avg_lane #(
      .ELEM_W(ELEM_W)
    ) u_lane (
      .a      (io.register_RA[l*ELEM_W +: ELEM_W]),
      .b      (io.register_RB[l*ELEM_W +: ELEM_W]),
      .op     (in_op),
      .pre    (pre_c[l*PW +: PW]),
      .fin_pre(fin_pre[l*PW +: PW]),
      .fin_op (fin_op),
      .res    (fin_res[l*ELEM_W +: ELEM_W])
    );
  end

  if (STAGES == 1) begin : g_single
    assign fin_pre     = pre_c;
    assign fin_op      = in_op;
    assign fin_tag     = io.in_tag;
    assign fin_v       = io.in_valid;
    assign io.in_ready = ld_last;
  end else begin : g_multi
    localparam int M = STAGES - 1;

    logic [M-1:0]     vm;
    logic [M-1:0]     ldm;
    logic [PRE_W-1:0] pre_q [M];
    simd_avg_op_e     op_q  [M];
    logic [TAG_W-1:0] tgq   [M];

    // A stage may load if any stage from it to
    // the output has a hole or the output drains.
    always_comb begin
      logic free;
      free = ld_last;
      ldm  = '0;
      for (int i = M - 1; i >= 0; i--) begin
        free   = free || !vm[i];
        ldm[i] = free;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vm <= '0;
        for (int i = 0; i < M; i++) begin
          pre_q[i] <= '0;
          op_q[i]  <= AVGR;
          tgq[i]   <= '0;
        end
      end else begin
        if (ldm[0]) begin
          vm[0] <= io.in_valid;
          if (io.in_valid) begin
            pre_q[0] <= pre_c;
            op_q[0]  <= in_op;
            tgq[0]   <= io.in_tag;
          end
        end
        for (int i = 1; i < M; i++) begin
          if (ldm[i]) begin
            vm[i] <= vm[i-1];
            if (vm[i-1]) begin
              pre_q[i] <= pre_q[i-1];
              op_q[i]  <= op_q[i-1];
              tgq[i]   <= tgq[i-1];
            end
          end
        end
      end
    end

    assign fin_pre     = pre_q[M-1];
    assign fin_op      = op_q[M-1];
    assign fin_tag     = tgq[M-1];
    assign fin_v       = vm[M-1];
    assign io.in_ready = ldm[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_last <= 1'b0;
      rt_q   <= '0;
      tag_q  <= '0;
      err_q  <= 1'b0;
    end else if (ld_last) begin
      v_last <= fin_v;
      if (fin_v) begin
        rt_q  <= fin_res;
        tag_q <= fin_tag;
        err_q <= (fin_op == RSVD);
      end
    end
  end

  assign io.out_valid   = v_last;
  assign io.register_RT = rt_q;
  assign io.out_tag     = tag_q;
  assign io.out_err     = err_q;

`ifdef SIMD_AVG_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (v_last && io.out_ready &&
          perf_ops != 32'hFFFF_FFFF)
        perf_ops <= perf_ops + 32'd1;
      if (v_last && !io.out_ready &&
          perf_stall != 32'hFFFF_FFFF)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_simd_avg_pipe.sv
// Self-checking bench for simd_avg_pipe (8-bit/2-stage and
// 16-bit/3-stage instances) against a per-element arithmetic model.
`timescale 1ns/1ps
module tb_simd_avg_pipe;
  localparam int RW = 128;
  localparam int TW = 7;

  typedef struct packed {
    logic [RW-1:0] rt;
    logic [TW-1:0] tag;
    logic          err;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  int acc_cnt = 0;
  int cyc = 0;
  int stall_seen = 0;
  res_t got_q[$];
  res_t exp_q[$];

  simd_avg_pipe_if #(.REG_W(RW), .TAG_W(TW)) io();
  simd_avg_pipe_if #(.REG_W(RW), .TAG_W(TW)) io16();

`ifdef SIMD_AVG_PERF_CNT_EN
  logic [31:0] perf_ops, perf_stall;
  logic [31:0] perf_ops16, perf_stall16;
`endif

  simd_avg_pipe #(
    .REG_W(RW), .ELEM_W(8), .STAGES(2), .TAG_W(TW)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .io(io)
`ifdef SIMD_AVG_PERF_CNT_EN
    , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
  );

  simd_avg_pipe #(
    .REG_W(RW), .ELEM_W(16), .STAGES(3), .TAG_W(TW)
  ) u_dut16 (
    .clk(clk), .rst_n(rst_n), .io(io16)
`ifdef SIMD_AVG_PERF_CNT_EN
    , .perf_ops(perf_ops16), .perf_stall(perf_stall16)
`endif
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n && io.out_valid && io.out_ready)
      got_q.push_back('{io.register_RT, io.out_tag, io.out_err});
    if (rst_n && io.out_valid && !io.out_ready)
      stall_seen++;
  end

  function automatic logic [RW-1:0] ref_rt(
    input logic [RW-1:0] a, input logic [RW-1:0] b,
    input logic [1:0] op, input int ew);
    logic [RW-1:0] r;
    longint unsigned m, ea, eb, e;
    r = '0;
    if (op == 2'b11) return r;
    m = (64'd1 << ew) - 64'd1;
    for (int i = 0; i < RW / ew; i++) begin
      ea = 64'(a >> (i * ew)) & m;
      eb = 64'(b >> (i * ew)) & m;
      case (op)
        2'b00:   e = (ea + eb + 1) / 2;
        2'b01:   e = (ea + eb) / 2;
        default: e = (ea >= eb) ? ea - eb : eb - ea;
      endcase
      r = r | (RW'(e) << (i * ew));
    end
    return r;
  endfunction

  function automatic logic [RW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Caller is at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic [RW-1:0] a, input logic [RW-1:0] b,
                      input logic [1:0] op, input logic [TW-1:0] tag);
    logic rdy;
    int n;
    io.in_valid = 1'b1;
    io.in_op = op;
    io.register_RA = a;
    io.register_RB = b;
    io.in_tag = tag;
    rdy = 1'b0;
    n = 0;
    while (!rdy && n < 100) begin
      @(negedge clk);
      rdy = io.in_ready;
      @(posedge clk);
      n++;
    end
    checks++;
    if (!rdy) begin
      fails++;
      $display("FAIL send_timeout: in_ready=0, required 1 within 100 cycles");
    end else begin
      exp_q.push_back('{ref_rt(a, b, op, 8), tag, op == 2'b11});
      acc_cnt++;
    end
    #1 io.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({io.out_valid, io.register_RT, io.out_tag, io.out_err} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%b rt=%h tag=%h err=%b, required all 0",
               io.out_valid, io.register_RT, io.out_tag, io.out_err);
    end
    #2 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (io.in_ready !== 1'b1 || io16.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b/%b, required 1/1", io.in_ready, io16.in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    got_q.delete();
    exp_q.delete();
    io.out_ready = 1'b1;
    io.in_valid = 1'b1;
    io.in_op = 2'b00;
    io.register_RA = {16{8'hFF}};
    io.register_RB = {16{8'hFF}};
    io.in_tag = 7'h01;
    @(negedge clk);
    checks++;
    if (io.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL lat_in_ready: got %b, required 1", io.in_ready);
    end
    @(posedge clk);
    #1 io.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (io.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL lat_early: out_valid=%b one cycle after accept, required 0", io.out_valid);
    end
    @(negedge clk);
    checks++;
    if (io.out_valid !== 1'b1 || io.register_RT !== {16{8'hFF}} || io.out_tag !== 7'h01) begin
      fails++;
      $display("FAIL lat_result: valid=%b rt=%h tag=%h, required 1 %h 01",
               io.out_valid, io.register_RT, io.out_tag, {16{8'hFF}});
    end
    @(posedge clk);
    #1;
    got_q.delete();
  endtask

  task automatic test_ops();
    logic [7:0] va [5] = '{8'h01, 8'hFF, 8'h01, 8'h10, 8'hF0};
    logic [7:0] vb [5] = '{8'h02, 8'hFF, 8'h02, 8'hF0, 8'h10};
    logic [1:0] vo [5] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10};
    logic [7:0] ve [5] = '{8'h02, 8'hFF, 8'h01, 8'hE0, 8'hE0};
    int n;
    got_q.delete();
    exp_q.delete();
    io.out_ready = 1'b1;
    for (int i = 0; i < 5; i++)
      send({16{va[i]}}, {16{vb[i]}}, vo[i], 7'(i + 2));
    n = 0;
    while (got_q.size() < 5 && n < 50) begin
      @(posedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      res_t g;
      checks++;
      if (got_q.size() == 0) begin
        fails++;
        $display("FAIL ops_missing: beat %0d not emitted, required rt=%h", i, {16{ve[i]}});
      end else begin
        g = got_q.pop_front();
        if (g.rt !== {16{ve[i]}} || g.tag !== 7'(i + 2) || g.err !== 1'b0) begin
          fails++;
          $display("FAIL ops_beat%0d: rt=%h tag=%h err=%b, required rt=%h tag=%h err=0",
                   i, g.rt, g.tag, g.err, {16{ve[i]}}, 7'(i + 2));
        end
      end
    end
    #1;
    exp_q.delete();
  endtask

  task automatic test_elem16();
    logic [RW-1:0] a, b;
    logic [1:0] op;
    int n;
    io16.out_ready = 1'b1;
    io16.in_valid = 1'b1;
    io16.in_op = 2'b00;
    io16.register_RA = {8{16'hFFFF}};
    io16.register_RB = {8{16'h0001}};
    io16.in_tag = 7'h33;
    @(negedge clk);
    @(posedge clk);
    #1 io16.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (io16.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL e16_early: out_valid=%b two cycles after accept, required 0", io16.out_valid);
    end
    @(negedge clk);
    checks++;
    if (io16.out_valid !== 1'b1 || io16.register_RT !== {8{16'h8000}} || io16.out_tag !== 7'h33) begin
      fails++;
      $display("FAIL e16_avgr: valid=%b rt=%h tag=%h, required 1 %h 33",
               io16.out_valid, io16.register_RT, io16.out_tag, {8{16'h8000}});
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      a = rnd128();
      b = rnd128();
      op = 2'(k);
      io16.in_valid = 1'b1;
      io16.in_op = op;
      io16.register_RA = a;
      io16.register_RB = b;
      io16.in_tag = 7'(k);
      @(posedge clk);
      #1 io16.in_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!io16.out_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (io16.out_valid !== 1'b1 || io16.register_RT !== ref_rt(a, b, op, 16)) begin
        fails++;
        $display("FAIL e16_rand%0d: valid=%b rt=%h, required 1 %h",
                 k, io16.out_valid, io16.register_RT, ref_rt(a, b, op, 16));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    int c0, n;
    got_q.delete();
    exp_q.delete();
    io.out_ready = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 20; i++)
      send(rnd128(), rnd128(), 2'($urandom_range(0, 3)), 7'($urandom));
    checks++;
    if (cyc - c0 !== 20) begin
      fails++;
      $display("FAIL b2b_throughput: 20 beats took %0d cycles, required 20", cyc - c0);
    end
    n = 0;
    while (got_q.size() < exp_q.size() && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL b2b_count: got %0d results, required %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      res_t g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        fails++;
        $display("FAIL b2b_beat: rt=%h tag=%h err=%b, required rt=%h tag=%h err=%b",
                 g.rt, g.tag, g.err, e.rt, e.tag, e.err);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    int drop_at, n;
    logic unstable;
    logic snap;
    res_t s;
    got_q.delete();
    exp_q.delete();
    acc_cnt = 0;
    drop_at = -1;
    unstable = 1'b0;
    snap = 1'b0;
    s = '0;
    io.out_ready = 1'b0;
    fork
      begin
        send(rnd128(), rnd128(), 2'b00, 7'h21);
        send(rnd128(), rnd128(), 2'b01, 7'h22);
        send(rnd128(), rnd128(), 2'b10, 7'h23);
      end
      begin
        repeat (5) begin
          @(negedge clk);
          if (!io.in_ready && drop_at < 0) drop_at = acc_cnt;
          if (io.out_valid) begin
            if (!snap) begin
              s = '{io.register_RT, io.out_tag, io.out_err};
              snap = 1'b1;
            end else if (s !== res_t'({io.register_RT, io.out_tag, io.out_err})) begin
              unstable = 1'b1;
            end
          end
        end
        @(posedge clk);
        #1 io.out_ready = 1'b1;
      end
    join
    checks++;
    if (drop_at !== 2) begin
      fails++;
      $display("FAIL bp_in_ready: in_ready dropped after %0d beats, required 2", drop_at);
    end
    checks++;
    if (unstable || !snap || s.rt !== exp_q[0].rt || s.tag !== 7'h21) begin
      fails++;
      $display("FAIL bp_hold: stable=%b held rt=%h tag=%h, required stable rt=%h tag=21",
               !unstable && snap, s.rt, s.tag, exp_q[0].rt);
    end
    n = 0;
    while (got_q.size() < 3 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (got_q.size() !== 3) begin
      fails++;
      $display("FAIL bp_count: got %0d results, required 3", got_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      res_t g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        fails++;
        $display("FAIL bp_order: rt=%h tag=%h err=%b, required rt=%h tag=%h err=%b",
                 g.rt, g.tag, g.err, e.rt, e.tag, e.err);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reserved();
    logic [RW-1:0] a, b;
    int n;
    res_t g;
    got_q.delete();
    exp_q.delete();
    io.out_ready = 1'b1;
    a = rnd128();
    b = rnd128();
    send(rnd128(), rnd128(), 2'b11, 7'h05);
    send(a, b, 2'b10, 7'h06);
    n = 0;
    while (got_q.size() < 2 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (got_q.size() !== 2) begin
      fails++;
      $display("FAIL rsvd_count: got %0d results, required 2", got_q.size());
    end else begin
      g = got_q.pop_front();
      if (g.rt !== '0 || g.err !== 1'b1 || g.tag !== 7'h05) begin
        fails++;
        $display("FAIL rsvd_beat: rt=%h err=%b tag=%h, required 0 1 05", g.rt, g.err, g.tag);
      end
      g = got_q.pop_front();
      checks++;
      if (g.rt !== ref_rt(a, b, 2'b10, 8) || g.err !== 1'b0 || g.tag !== 7'h06) begin
        fails++;
        $display("FAIL rsvd_next: rt=%h err=%b tag=%h, required %h 0 06",
                 g.rt, g.err, g.tag, ref_rt(a, b, 2'b10, 8));
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    int n;
    logic done;
`ifdef SIMD_AVG_PERF_CNT_EN
    logic [31:0] ops0, stall0;
    int seen0;
    ops0 = perf_ops;
    stall0 = perf_stall;
    seen0 = stall_seen;
`endif
    got_q.delete();
    exp_q.delete();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(rnd128(), rnd128(), 2'($urandom_range(0, 3)), 7'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 io.out_ready = ($urandom_range(0, 3) != 0);
        end
        io.out_ready = 1'b1;
      end
    join
    n = 0;
    while (got_q.size() < exp_q.size() && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (got_q.size() !== 150 || exp_q.size() !== 150) begin
      fails++;
      $display("FAIL rand_count: got %0d results for %0d sent, required 150",
               got_q.size(), exp_q.size());
    end
`ifdef SIMD_AVG_PERF_CNT_EN
    checks++;
    if (perf_ops - ops0 !== 32'd150 || perf_stall - stall0 !== 32'(stall_seen - seen0)) begin
      fails++;
      $display("FAIL rand_perf: ops+%0d stall+%0d, required ops+150 stall+%0d",
               perf_ops - ops0, perf_stall - stall0, stall_seen - seen0);
    end
`endif
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      res_t g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        fails++;
        $display("FAIL rand_beat: rt=%h tag=%h err=%b, required rt=%h tag=%h err=%b",
                 g.rt, g.tag, g.err, e.rt, e.tag, e.err);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_midflight();
    got_q.delete();
    exp_q.delete();
    io.out_ready = 1'b0;
    send(rnd128(), rnd128(), 2'b00, 7'h11);
    send(rnd128(), rnd128(), 2'b01, 7'h12);
    checks++;
    if (io.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL rst_inflight: out_valid=%b before reset, required 1", io.out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({io.out_valid, io.register_RT, io.out_tag, io.out_err} !== '0) begin
      fails++;
      $display("FAIL rst_clear: valid=%b rt=%h tag=%h err=%b, required all 0",
               io.out_valid, io.register_RT, io.out_tag, io.out_err);
    end
`ifdef SIMD_AVG_PERF_CNT_EN
    checks++;
    if ({perf_ops, perf_stall, perf_ops16, perf_stall16} !== '0) begin
      fails++;
      $display("FAIL rst_perf: ops=%0d stall=%0d ops16=%0d stall16=%0d, required 0",
               perf_ops, perf_stall, perf_ops16, perf_stall16);
    end
`endif
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1 io.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() !== 0 || io.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_no_emit: %0d results after reset, out_valid=%b, required 0 0",
               got_q.size(), io.out_valid);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    io.in_valid = 1'b0;
    io.in_op = 2'b00;
    io.register_RA = '0;
    io.register_RB = '0;
    io.in_tag = '0;
    io.out_ready = 1'b1;
    io16.in_valid = 1'b0;
    io16.in_op = 2'b00;
    io16.register_RA = '0;
    io16.register_RB = '0;
    io16.in_tag = '0;
    io16.out_ready = 1'b1;
    test_reset();
    test_latency();
    test_ops();
    test_elem16();
    test_back_to_back();
    test_backpressure();
    test_reserved();
    test_random();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
